shot_control: RTL and testbench
===============================

SHOT_CONTROL -- requirements
Module: shot_control

Interface
REQ-001 SHALL have parameter SHOT_NUM, default 2, number of shot slots (1..8).
REQ-002 SHALL have parameter SHOT_SPEED, default 4, pixels moved upward per tick.
REQ-003 SHALL have parameter TICK_DIV, default 500000, clocks per movement tick.
REQ-004 SHALL have parameter COOLDOWN, default 20, ticks between accepted fires.
REQ-005 SHALL have parameter TOP_Y, default 16, shot retired when y < TOP_Y.
REQ-006 Ports:
- clock, input, 1: single clock.
- reset, input, 1: asynchronous, active-high.
- enable, input, 1: 0 freezes ticks and fires.
- fire, input, 1: one-cycle fire request.
- p_x, p_y, input, 10 each: paddle centre.
- bm_ready, input, 1: block-memory access done.
- bm_block, input, 4: block value read (0 = empty).
- bm_enable, output, 1: one-cycle access request.
- bm_row, bm_col, output, 5 each: block address.
- bm_func, output, 2: access type.
- s_x, s_y, output, SHOT_NUM*10 each: packed shot positions; slot i at [10i+9:10i].
- s_active, output, SHOT_NUM: slot occupied.
- hit, output, 1: one-cycle pulse per block struck.
- busy, output, 1: FSM not in IDLE.

Function
REQ-007 An internal tick SHALL pulse one cycle every TICK_DIV clocks while enable=1; the counter holds while enable=0.
REQ-008 FSM states SHALL be IDLE, MOVE, RD_REQ, RD_WAIT, HIT_REQ, HIT_WAIT, NEXT.
REQ-009 A fire pulse SHALL set a one-deep pending flag; repeated pulses coalesce.
REQ-010 In IDLE with fire pending: if the cooldown counter is 0 and a slot is free, the lowest-index free slot SHALL load x=p_x, y=p_y-8, active=1, and the cooldown reload to COOLDOWN; pending clears in either case, so a blocked fire is dropped.
REQ-011 A tick arriving outside IDLE SHALL be held pending (one deep) and serviced on return to IDLE; fire has priority over the tick in the same IDLE cycle.
REQ-012 On a tick, the cooldown SHALL decrement, saturating at 0, and MOVE SHALL apply y-=SHOT_SPEED to every active slot in one cycle; a slot with y < TOP_Y+SHOT_SPEED SHALL be deactivated instead.
REQ-013 After MOVE, slots i=0..SHOT_NUM-1 SHALL be checked in order; inactive slots skip to NEXT in one cycle.
REQ-014 RD_REQ SHALL drive bm_enable=1 for one cycle with bm_func=READ, bm_row=y[8:4], bm_col=x[9:5]; rows >= 16 (y >= 256) skip the access.
REQ-015 RD_WAIT SHALL wait for bm_ready with no timeout. If bm_block != 0, go to HIT_REQ (bm_func=HIT, same address); otherwise go to NEXT.
REQ-016 On bm_ready in HIT_WAIT, the slot SHALL be deactivated and hit pulse for one cycle.
REQ-017 bm_row, bm_col and bm_func SHALL hold stable from request until bm_ready.
REQ-018 After the last slot, NEXT SHALL return to IDLE; busy=0 only in IDLE.
REQ-019 Deasserting enable mid-sequence SHALL NOT abort it; the sequence completes, then the FSM idles.
REQ-020 Widths: y subtraction is 10-bit unsigned, with underflow guarded by REQ-012.

Reset
REQ-021 Reset SHALL force IDLE; all outputs 0, including s_x, s_y, s_active, bm_enable and hit. The tick counter, cooldown and pending flags clear.
REQ-022 Reset mid-access SHALL abandon the access; no bm_enable is issued afterwards until a new sequence starts.

Configuration
REQ-023 With SHOT_AUTOFIRE_EN defined, fire SHALL be level-sensitive: while fire=1, pending re-sets every cycle, so shots launch each time the cooldown reaches 0.
REQ-024 Without SHOT_AUTOFIRE_EN, fire SHALL be pulse-only per REQ-009.

Structure
REQ-025 The shared package arkanoid_pkg SHALL hold BM_FUNC_READ=2'b00, BM_FUNC_HIT=2'b01, BLOCK_W_LOG2=5, BLOCK_H_LOG2=4 and BLOCK_ROWS=16.
REQ-026 The tick generator SHALL be sub-module tick_divider (parameter DIV; ports clock, reset, enable, tick).

Verification
REQ-027 Defaults, TICK_DIV=4. Fire with p_x=100, p_y=400 -> slot0 active, x=100, y=392; after 1 tick, y=388.
REQ-028 Fire twice 1 tick apart -> second fire dropped by cooldown; after 20 ticks, fire -> slot1 loads.
REQ-029 Shot at y=18 with TOP_Y=16 -> next tick deactivates it; no bm_enable for that slot.
REQ-030 Shot at x=70, y=120, bm_block=3 -> READ at row 7, col 2, then HIT at the same address, then hit pulse and slot cleared. bm_ready is delayed 5 cycles; the address is held throughout.
REQ-031 Reset asserted in RD_WAIT -> all outputs 0 within the same cycle; no further bm_enable.
REQ-032 SHOT_AUTOFIRE_EN defined, fire held high for 45 ticks -> exactly 2 shots launched (ticks 0 and 20), since slots are full at tick 40.

Source files
------------

// File: rtl/arkanoid_pkg.sv
// arkanoid_pkg: shared block-memory access codes, block geometry and shot FSM states
package arkanoid_pkg;

    localparam logic [1:0] BM_FUNC_READ = 2'b00;
    localparam logic [1:0] BM_FUNC_HIT  = 2'b01;
    localparam int         BLOCK_W_LOG2 = 5;
    localparam int         BLOCK_H_LOG2 = 4;
    localparam int         BLOCK_ROWS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        RD_REQ,
        RD_WAIT,
        HIT_REQ,
        HIT_WAIT,
        NEXT
    } shot_state_t;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every DIV enabled clocks; the count holds while disabled
module tick_divider #(
    parameter int DIV = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int DW = (DIV < 2) ? 1 : $clog2(DIV);

    logic [DW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = r_cnt == DW'(DIV - 1);
    assign tick   = enable & w_wrap;

    // advance only while enabled, wrapping after DIV counts
    always_ff @(posedge clock or posedge reset)
        if (reset) r_cnt <= '0;
        else if (enable) r_cnt <= w_wrap ? '0 : r_cnt + DW'(1);

endmodule

// File: rtl/shot_control.sv
// shot_control: player shot slots, tick-driven movement and block-memory collision walk
// Optional SHOT_AUTOFIRE_EN: fire is level-sensitive instead of edge-triggered
module shot_control
    import arkanoid_pkg::*;
#(
    parameter int SHOT_NUM   = 2,
    parameter int SHOT_SPEED = 4,
    parameter int TICK_DIV   = 500000,
    parameter int COOLDOWN   = 20,
    parameter int TOP_Y      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fire,
    input  logic [9:0]             p_x,
    input  logic [9:0]             p_y,
    input  logic                   bm_ready,
    input  logic [3:0]             bm_block,
    output logic                   bm_enable,
    output logic [4:0]             bm_row,
    output logic [4:0]             bm_col,
    output logic [1:0]             bm_func,
    output logic [SHOT_NUM*10-1:0] s_x,
    output logic [SHOT_NUM*10-1:0] s_y,
    output logic [SHOT_NUM-1:0]    s_active,
    output logic                   hit,
    output logic                   busy
);

    localparam int         IW          = (SHOT_NUM < 2) ? 1 : $clog2(SHOT_NUM);
    localparam int         CW          = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [9:0] RETIRE_Y    = 10'(TOP_Y + SHOT_SPEED);
    localparam logic [9:0] ROW_LIMIT_Y = 10'(BLOCK_ROWS << BLOCK_H_LOG2);

    shot_state_t         r_state, w_next;
    logic [9:0]          r_sx [SHOT_NUM];
    logic [9:0]          r_sy [SHOT_NUM];
    logic [SHOT_NUM-1:0] r_act;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cool;
    logic                r_fire_pend;
    logic                r_tick_pend;
    logic                w_tick;
    logic                w_fire_req;
    logic                w_fire_take;
    logic                w_tick_take;
    logic                w_launch;
    logic                w_free_ok;
    logic [IW-1:0]       w_free_idx;
    logic [9:0]          w_cur_y;
    logic                w_cur_live;
    logic                w_last;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

`ifdef SHOT_AUTOFIRE_EN
    assign w_fire_req = enable & fire;
`else
    logic r_fire_q;

    assign w_fire_req = enable & fire & ~r_fire_q;

    // previous fire level, so a held button launches only once
    always_ff @(posedge clock or posedge reset)
        if (reset) r_fire_q <= 1'b0;
        else r_fire_q <= fire;
`endif

    // fire wins the IDLE cycle; a tick is taken only when no fire is waiting
    assign w_fire_take = (r_state == IDLE) & r_fire_pend;
    assign w_tick_take = (r_state == IDLE) & ~r_fire_pend & (w_tick | r_tick_pend);
    assign w_launch    = w_fire_take & (r_cool == '0) & w_free_ok;
    assign w_cur_y     = r_sy[r_idx];
    assign w_cur_live  = r_act[r_idx] & (w_cur_y < ROW_LIMIT_Y);
    assign w_last      = r_idx == IW'(SHOT_NUM - 1);

    // lowest-index free slot: scan downward so the lowest free index is written last
    always_comb begin
        w_free_ok  = 1'b0;
        w_free_idx = '0;
        for (int i = SHOT_NUM - 1; i >= 0; i--)
            if (!r_act[i]) begin
                w_free_ok  = 1'b1;
                w_free_idx = IW'(i);
            end
    end

    // one-deep fire and tick requests; a request arriving while one is consumed merges into it
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_fire_pend <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_fire_pend <= ~w_fire_take & (r_fire_pend | w_fire_req);
            r_tick_pend <= ~w_tick_take & (r_tick_pend | w_tick);
        end

    // cooldown reloads on a launch and counts down once per serviced tick, stopping at zero
    always_ff @(posedge clock or posedge reset)
        if (reset) r_cool <= '0;
        else if (w_launch) r_cool <= CW'(COOLDOWN);
        else if (w_tick_take && r_cool != '0) r_cool <= r_cool - CW'(1);

    // slot state: launch in IDLE, bulk move or retire in MOVE, clear on a confirmed hit
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            for (int i = 0; i < SHOT_NUM; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
            r_act <= '0;
        end else if (w_launch) begin
            r_sx[w_free_idx]  <= p_x;
            r_sy[w_free_idx]  <= p_y - 10'd8;
            r_act[w_free_idx] <= 1'b1;
        end else if (r_state == MOVE) begin
            for (int i = 0; i < SHOT_NUM; i++)
                if (r_act[i]) begin
                    if (r_sy[i] < RETIRE_Y) r_act[i] <= 1'b0;
                    else r_sy[i] <= r_sy[i] - 10'(SHOT_SPEED);
                end
        end else if (hit) r_act[r_idx] <= 1'b0;

    // slot cursor for the collision walk, restarted by every MOVE
    always_ff @(posedge clock or posedge reset)
        if (reset) r_idx <= '0;
        else if (r_state == MOVE) r_idx <= '0;
        else if (r_state == NEXT && !w_last) r_idx <= r_idx + IW'(1);

    // state register
    always_ff @(posedge clock or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    // next state: empty, retired or off-grid slots skip straight to NEXT
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_tick_take ? MOVE : IDLE;
            MOVE:     w_next = RD_REQ;
            RD_REQ:   w_next = w_cur_live ? RD_WAIT : NEXT;
            RD_WAIT:  w_next = bm_ready ? ((bm_block != 4'd0) ? HIT_REQ : NEXT) : RD_WAIT;
            HIT_REQ:  w_next = HIT_WAIT;
            HIT_WAIT: w_next = bm_ready ? NEXT : HIT_WAIT;
            NEXT:     w_next = w_last ? IDLE : RD_REQ;
            default:  w_next = IDLE;
        endcase
    end

    // outputs: address follows the cursor slot, which cannot change while an access is open
    always_comb begin
        bm_enable = (r_state == RD_REQ && w_cur_live) || r_state == HIT_REQ;
        bm_func   = (r_state == HIT_REQ || r_state == HIT_WAIT) ? BM_FUNC_HIT : BM_FUNC_READ;
        bm_row    = w_cur_y[BLOCK_H_LOG2 +: 5];
        bm_col    = r_sx[r_idx][BLOCK_W_LOG2 +: 5];
        hit       = r_state == HIT_WAIT && bm_ready;
        busy      = r_state != IDLE;
    end

    for (genvar g = 0; g < SHOT_NUM; g++) begin : g_pack
        assign s_x[10*g +: 10] = r_sx[g];
        assign s_y[10*g +: 10] = r_sy[g];
    end

    assign s_active = r_act;

endmodule

// File: tb/tb_shot_control.sv
// tb_shot_control: directed checks of launch, cooldown, movement, collision access and reset
`timescale 1ns/1ps
module tb_shot_control;

    localparam int N = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            fire = 1'b0;
    logic [9:0]      p_x = '0;
    logic [9:0]      p_y = '0;
    logic            bm_ready = 1'b0;
    logic [3:0]      bm_block = '0;
    logic            bm_enable;
    logic [4:0]      bm_row;
    logic [4:0]      bm_col;
    logic [1:0]      bm_func;
    logic [N*10-1:0] s_x;
    logic [N*10-1:0] s_y;
    logic [N-1:0]    s_active;
    logic            hit;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    int   n_bm = 0;
    int   n0;
    logic h;
    logic seen;

    shot_control #(.TICK_DIV(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .fire      (fire),
        .p_x       (p_x),
        .p_y       (p_y),
        .bm_ready  (bm_ready),
        .bm_block  (bm_block),
        .bm_enable (bm_enable),
        .bm_row    (bm_row),
        .bm_col    (bm_col),
        .bm_func   (bm_func),
        .s_x       (s_x),
        .s_y       (s_y),
        .s_active  (s_active),
        .hit       (hit),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (bm_enable === 1'b1) n_bm <= n_bm + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; fire = 1'b0; bm_ready = 1'b0; bm_block = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // one fire pulse right after reset; the slot is loaded by the second following edge
    task automatic start(input logic [9:0] x, input logic [9:0] y);
        p_x = x; p_y = y; enable = 1'b1; fire = 1'b1;
        @(negedge clock);
        fire = 1'b0;
        @(negedge clock);
    endtask

    // consume exactly one serviced tick: busy must rise and fall again
    task automatic wait_seq(input string tag);
        int   t;
        logic rose;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin @(negedge clock); t++; end
        rose = busy === 1'b1;
        while (busy !== 1'b0 && t < 200) begin @(negedge clock); t++; end
        check(tag, {rose, busy}, 2'b10);
    endtask

    // pulse fire mid-sequence so it is serviced in the IDLE cycle right after it
    task automatic fire_during_seq(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin @(negedge clock); t++; end
        fire = 1'b1;
        @(negedge clock);
        fire = 1'b0;
        while (busy !== 1'b0 && t < 200) begin @(negedge clock); t++; end
        check(tag, busy, 1'b0);
        @(negedge clock);
    endtask

    task automatic wait_bm(input string tag);
        int t;
        t = 0;
        while (bm_enable !== 1'b1 && t < 100) begin @(negedge clock); t++; end
        check(tag, bm_enable, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin @(negedge clock); t++; end
        check(tag, busy, 1'b0);
    endtask

    // answer an open access after lat cycles, checking the address holds and no re-request
    task automatic respond(input string tag, input int lat, input logic [3:0] blk, output logic hit_seen);
        logic [11:0] addr;
        logic        stable;
        addr   = {bm_row, bm_col, bm_func};
        stable = 1'b1;
        repeat (lat) begin
            @(negedge clock);
            stable &= ({bm_row, bm_col, bm_func} === addr) && (bm_enable === 1'b0);
        end
        check(tag, stable, 1'b1);
        bm_ready = 1'b1; bm_block = blk;
        #1 hit_seen = hit;
        @(negedge clock);
        bm_ready = 1'b0; bm_block = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        check("reset_outs", {bm_enable, hit, busy, s_active, s_x, s_y, bm_row, bm_col, bm_func}, 64'd0);

        // launch, first move, cooldown drop and reload boundary
        start(10'd100, 10'd400);
        check("launch0", {s_active, s_x[9:0], s_y[9:0]}, {2'b01, 10'd100, 10'd392});
        fire_during_seq("cd_seq1");
        check("move1", {s_active, s_y[9:0]}, {2'b01, 10'd388});
        for (int i = 2; i <= 18; i++) wait_seq("cd_seq");
        fire_during_seq("cd_seq19");
        check("cd_drop19", s_active, 2'b01);
        fire_during_seq("cd_seq20");
        check("cd_load20", {s_active, s_x[19:10], s_y[19:10]}, {2'b11, 10'd100, 10'd392});
        check("move20", s_y[9:0], 10'd312);

        // shot at y=18 retires on the next tick without touching block memory
        do_reset();
        start(10'd300, 10'd26);
        check("low_launch", {s_active, s_y[9:0]}, {2'b01, 10'd18});
        n0 = n_bm;
        wait_seq("low_seq");
        check("low_retired", s_active, 2'b00);
        check("low_no_bm", n_bm - n0, 0);

        // shot at y=20 survives to y=16, reads an empty block, retires next tick
        do_reset();
        start(10'd64, 10'd28);
        wait_bm("edge_rd");
        check("edge_addr", {bm_row, bm_col, bm_func, s_y[9:0]}, {5'd1, 5'd2, 2'b00, 10'd16});
        respond("edge_hold", 2, 4'd0, h);
        check("edge_nohit", h, 1'b0);
        wait_idle("edge_idle");
        check("edge_alive", s_active, 2'b01);
        wait_seq("edge_seq2");
        check("edge_retired", s_active, 2'b00);

        // read then hit at row 7 col 2, slow ready, enable dropped mid-sequence
        do_reset();
        start(10'd70, 10'd128);
        check("hit_launch", s_y[9:0], 10'd120);
        wait_bm("rd_req");
        check("rd_addr", {busy, bm_row, bm_col, bm_func}, {1'b1, 5'd7, 5'd2, 2'b00});
        enable = 1'b0;
        respond("rd_hold", 5, 4'd3, h);
        check("rd_nohit", h, 1'b0);
        check("hit_req", {bm_enable, bm_row, bm_col, bm_func}, {1'b1, 5'd7, 5'd2, 2'b01});
        respond("hit_hold", 5, 4'd0, h);
        check("hit_pulse", h, 1'b1);
        check("hit_once", {hit, s_active}, 3'b000);
        wait_idle("hit_idle");
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= busy;
        end
        check("frozen", seen, 1'b0);

        // reset while waiting for the read answer
        do_reset();
        start(10'd70, 10'd128);
        wait_bm("rst_rd");
        @(negedge clock);
        reset = 1'b1;
        #1 check("rst_outs", {bm_enable, hit, busy, s_active, s_x, s_y, bm_row, bm_col, bm_func}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        n0 = n_bm;
        repeat (40) @(negedge clock);
        check("rst_no_bm", n_bm - n0, 0);
        check("rst_empty", s_active, 2'b00);

        // fire held for 45 ticks
        do_reset();
        p_x = 10'd200; p_y = 10'd1000; enable = 1'b1; fire = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 45; i++) wait_seq("held_seq");
        fire = 1'b0;
`ifdef SHOT_AUTOFIRE_EN
        check("held_active", s_active, 2'b11);
        check("held_y", {s_y[19:10], s_y[9:0]}, {10'd892, 10'd812});
`else
        check("held_active", s_active, 2'b01);
        check("held_y", s_y[9:0], 10'd812);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
